midi_router_matrix: RTL and testbench
=====================================

Name: midi_router_matrix

Overview:
- Parametrised successor to the board bring-up switcher.
- Routes N_IN synchronised MIDI serial inputs to N_OUT registered MIDI outputs through a per-output source mask.
- Masks are written and read back by the MCU over a 16-bit SPI slave frame.
- Sits at the FPGA top level between the GPIO MIDI pins and the MCU SPI port; all SPI pins are oversampled in the clk domain.

Parameters:
- N_IN, 8, number of MIDI inputs (1..8; the mask occupies data byte bits [N_IN-1:0]).
- N_OUT, 8, number of MIDI outputs (1..128; the address field is 7 bits).
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers (>=2).

Ports:
- clk  in  1  system clock; must be at least 4x spi_clk.
- reset  in  1  synchronous, active-high reset.
- midi_in  in  N_IN  asynchronous MIDI UART inputs, idle high.
- midi_out  out  N_OUT  registered MIDI outputs, idle high.
- spi_clk  in  1  SPI clock, mode 0.
- spi_mosi  in  1  SPI data in, MSB first.
- spi_ss  in  1  SPI select, active low.
- spi_miso  out  1  SPI data out, registered.
- cfg_commit  out  1  one-clk pulse when a write frame is applied.
- frame_err  out  1  sticky flag for a malformed frame; cleared by reset or by a write frame to address 0x7F.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous, active-high.
- Reset values:
  - midi_out = all 1s.
  - spi_miso = 0, cfg_commit = 0, frame_err = 0.
  - Bit counter = 0, state = IDLE.
  - mask[j] = one-hot(j) for j < N_IN (passthrough), else 0.
- Synchronisation:
  - midi_in, spi_clk, spi_mosi and spi_ss each pass through SYNC_STAGES flops.
  - spi_clk rise/fall are detected from the last two synchronised samples.
- Routing:
  - midi_out[j] <= AND over i of (midi_in_s[i] | ~mask[j][i]).
  - A zero mask gives constant 1 (idle).
  - Latency from midi_in pin to midi_out = SYNC_STAGES+1 clk.
- Frame format (16 bits, MSB first):
  - bit15 = W (1 write, 0 read).
  - bits14:8 = output index.
  - bits7:0 = mask data.
- MOSI is sampled on synchronised spi_clk rise. MISO is updated on synchronised spi_clk fall.
- State machine:
  - IDLE: spi_ss_s=1, miso=0. The falling edge of spi_ss_s goes to CMD and clears the shift register and count.
  - CMD: shift 8 bits. At count 8, latch index and load tx_reg = mask[index] (0 if index >= N_OUT), then go to DATA.
  - DATA: shift 8 more bits. miso = tx_reg MSB on each fall, so the current mask is read back during the data byte of any frame. At count 16 go to DONE.
  - DONE: a further spi_clk rise goes to ERR. spi_ss_s rise goes to IDLE and commits.
  - ERR: wait for spi_ss_s rise, then go to IDLE with no commit.
- Ending a frame early: spi_ss_s rise in CMD or DATA sets frame_err and discards the frame.
- Extra bits: a further spi_clk rise in DONE sets frame_err and discards the frame.
- Commit (on DONE to IDLE):
  - W=1 and index < N_OUT: mask[index] <= data[N_IN-1:0] and cfg_commit=1 for one clk. New routing takes effect on the next clk.
  - W=1 and index = 0x7F: clear frame_err, no mask change, cfg_commit=1.
  - W=1 and any other out-of-range index: ignored, no pulse.
  - W=0: no change.
- Mask bits above N_IN are ignored on write and read back as 0.
- Reset asserted mid-frame forces IDLE and defaults regardless of spi_ss; the remainder of that frame is ignored until spi_ss goes high then low.
- Simultaneous commit and routing: routing uses the old mask in the commit clk and the new mask from the next clk.

Decomposition:
- Shared include midi_router_defs.vh:
  - FRAME_BITS=16, CMD_BITS=8, W_BIT=15.
  - ADDR_CLR_ERR=7'h7F.
  - State encodings IDLE/CMD/DATA/DONE/ERR.
- Sub-module spi_frame_rx:
  - Contains the synchronisers, edge detection, bit counter, state machine and shift/tx registers.
  - Outputs frame_valid, frame_word[15:0] and err_pulse.
  - Accepts tx_load_data from the parent at count 8.
- Top level contains the mask bank, routing logic and status flags.

Test Plan:
- Reset then toggle midi_in[3]: midi_out[3] follows after SYNC_STAGES+1 clk; the other outputs stay 1.
- Write frame 0x8205 (out 2, mask=0b101): cfg_commit pulses once; midi_out[2] = midi_in[0] & midi_in[2]; mask[3] is unchanged.
- Read frame 0x0200 after the previous write: spi_miso shifts 0x05 during data bits 8-15; no mask change and no cfg_commit.
- spi_ss high after 11 bits: frame_err=1, masks unchanged. Then send write 0xFF00: frame_err=0.
- 17-bit frame with a write to out 1: frame_err=1, mask[1] is still the reset one-hot.
- Reset asserted at bit 12 of a write frame: masks return to defaults, no commit, and the next complete frame is accepted.

Source files
------------

// File: rtl/midi_router_matrix_pkg.sv
// Shared frame constants and receiver state encoding for the MIDI router.
package midi_router_matrix_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CMD_BITS   = 8;
  localparam int W_BIT      = 15;

  // Writing to this address clears the sticky frame error.
  localparam logic [6:0] ADDR_CLR_ERR = 7'h7F;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_DATA = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } rx_state_e;

endpackage

// File: rtl/midi_router_matrix_spi_frame_rx.sv
// SPI mode-0 slave frame receiver, oversampled in the clk domain.
// Delivers a 16-bit frame on a clean select release, flags malformed frames,
// and shifts the addressed mask back out on MISO during the data byte.
module midi_router_matrix_spi_frame_rx
  import midi_router_matrix_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_clk,
  input  logic        spi_mosi,
  input  logic        spi_ss,
  input  logic [7:0]  tx_load_data,
  output logic [6:0]  cmd_index,
  output logic        frame_valid,
  output logic [15:0] frame_word,
  output logic        err_pulse,
  output logic        spi_miso
);

  // Pin vector layout: bit0 spi_clk, bit1 spi_mosi, bit2 spi_ss.
  logic [SYNC_STAGES-1:0][2:0] pin_sync_q, pin_sync_d;
  logic        sclk_prev_q, sclk_prev_d;
  logic        ss_prev_q, ss_prev_d;
  logic        sclk_s, mosi_s, ss_s;
  logic        sclk_rise_s, sclk_fall_s, ss_rise_s, ss_fall_s;

  rx_state_e   state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] shift_q, shift_d;
  logic [7:0]  tx_q, tx_d;
  logic        miso_q, miso_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  assign sclk_s = pin_sync_q[SYNC_STAGES-1][0];
  assign mosi_s = pin_sync_q[SYNC_STAGES-1][1];
  assign ss_s   = pin_sync_q[SYNC_STAGES-1][2];

  assign sclk_rise_s = sclk_s & ~sclk_prev_q;
  assign sclk_fall_s = ~sclk_s & sclk_prev_q;
  assign ss_rise_s   = ss_s & ~ss_prev_q;
  assign ss_fall_s   = ~ss_s & ss_prev_q;

  // Index bits as they will stand once the 8th command bit is shifted in,
  // so the parent can present the addressed mask on that same clock.
  assign cmd_index   = {shift_q[5:0], mosi_s};
  assign frame_word  = shift_q;
  assign frame_valid = valid_q;
  assign err_pulse   = err_q;
  assign spi_miso    = miso_q;

  // Synchroniser chains and one-sample history for edge detection.
  always_comb begin
    pin_sync_d[0] = {spi_ss, spi_mosi, spi_clk};
    for (int k = 1; k < SYNC_STAGES; k++) begin
      pin_sync_d[k] = pin_sync_q[k-1];
    end
    sclk_prev_d = sclk_s;
    ss_prev_d   = ss_s;
  end

  // Frame state machine: shifting, readback load, termination checks.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    miso_d  = miso_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (ss_fall_s) begin
          state_d = ST_CMD;
          shift_d = 16'd0;
          cnt_d   = 5'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (ss_rise_s) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (sclk_rise_s) begin
          shift_d = {shift_q[14:0], mosi_s};
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'(CMD_BITS - 1)) begin
            tx_d    = tx_load_data;
            state_d = ST_DATA;
          end else begin
            state_d = ST_CMD;
          end
        end else begin
          state_d = ST_CMD;
        end
      end
      ST_DATA: begin
        if (ss_rise_s) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (sclk_rise_s) begin
          shift_d = {shift_q[14:0], mosi_s};
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'(FRAME_BITS - 1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DATA;
          end
        end else if (sclk_fall_s) begin
          miso_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_DONE: begin
        if (ss_rise_s) begin
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end else if (sclk_rise_s) begin
          err_d   = 1'b1;
          state_d = ST_ERR;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_ERR: begin
        if (ss_rise_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ERR;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register stage; synchronisers clear to 0 so a select held low across
  // reset is not mistaken for a new frame start.
  always_ff @(posedge clk) begin
    if (reset) begin
      pin_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= 5'd0;
      shift_q     <= 16'd0;
      tx_q        <= 8'd0;
      miso_q      <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      pin_sync_q  <= pin_sync_d;
      sclk_prev_q <= sclk_prev_d;
      ss_prev_q   <= ss_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: rtl/midi_router_matrix.sv
// MIDI router matrix: N_IN synchronised inputs routed to N_OUT registered
// outputs through per-output source masks configured over SPI.
module midi_router_matrix
  import midi_router_matrix_pkg::*;
#(
  parameter int N_IN        = 8,
  parameter int N_OUT       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IN-1:0]  midi_in,
  output logic [N_OUT-1:0] midi_out,
  input  logic             spi_clk,
  input  logic             spi_mosi,
  input  logic             spi_ss,
  output logic             spi_miso,
  output logic             cfg_commit,
  output logic             frame_err
);

  logic [SYNC_STAGES-1:0][N_IN-1:0] midi_sync_q, midi_sync_d;
  logic [N_IN-1:0]             midi_in_s;
  logic [N_OUT-1:0][N_IN-1:0]  mask_q, mask_d;
  logic [N_OUT-1:0]            midi_out_q, midi_out_d;
  logic                        cfg_commit_q, cfg_commit_d;
  logic                        frame_err_q, frame_err_d;

  logic [6:0]                  cmd_index_s;
  logic [7:0]                  tx_load_data_s;
  logic                        frame_valid_s;
  logic [15:0]                 frame_word_s;
  logic                        err_pulse_s;
  logic                        wr_s;
  logic [6:0]                  wr_index_s;
  logic [N_IN-1:0]             wr_mask_s;
  logic                        wr_in_range_s;

  // Default routing: output j listens to input j only, if that input exists.
  function automatic logic [N_IN-1:0] passthrough_mask(input int j);
    logic [N_IN-1:0] m;
    if (j < N_IN) begin
      m = N_IN'(1) << j;
    end else begin
      m = '0;
    end
    return m;
  endfunction

  midi_router_matrix_spi_frame_rx #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rx (
    .clk          (clk),
    .reset        (reset),
    .spi_clk      (spi_clk),
    .spi_mosi     (spi_mosi),
    .spi_ss       (spi_ss),
    .tx_load_data (tx_load_data_s),
    .cmd_index    (cmd_index_s),
    .frame_valid  (frame_valid_s),
    .frame_word   (frame_word_s),
    .err_pulse    (err_pulse_s),
    .spi_miso     (spi_miso)
  );

  assign midi_in_s     = midi_sync_q[SYNC_STAGES-1];
  assign wr_s          = frame_word_s[W_BIT];
  assign wr_index_s    = frame_word_s[W_BIT-1:CMD_BITS];
  assign wr_mask_s     = frame_word_s[N_IN-1:0];
  assign wr_in_range_s = ({25'd0, wr_index_s} < 32'(N_OUT));

  assign midi_out   = midi_out_q;
  assign cfg_commit = cfg_commit_q;
  assign frame_err  = frame_err_q;

  // MIDI input synchroniser chain.
  always_comb begin
    midi_sync_d[0] = midi_in;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      midi_sync_d[k] = midi_sync_q[k-1];
    end
  end

  // Routing: an output is low whenever any of its selected inputs is low.
  always_comb begin
    midi_out_d = '1;
    for (int j = 0; j < N_OUT; j++) begin
      midi_out_d[j] = &(midi_in_s | ~mask_q[j]);
    end
  end

  // Readback value for the addressed output; unmapped addresses read 0.
  always_comb begin
    tx_load_data_s = 8'd0;
    for (int j = 0; j < N_OUT; j++) begin
      if (cmd_index_s == 7'(j)) begin
        tx_load_data_s = 8'(mask_q[j]);
      end else begin
        tx_load_data_s = tx_load_data_s;
      end
    end
  end

  // Apply completed frames and maintain the sticky error flag.
  always_comb begin
    mask_d       = mask_q;
    cfg_commit_d = 1'b0;
    frame_err_d  = frame_err_q;
    if (frame_valid_s && wr_s) begin
      if (wr_in_range_s) begin
        for (int j = 0; j < N_OUT; j++) begin
          if (wr_index_s == 7'(j)) begin
            mask_d[j] = wr_mask_s;
          end else begin
            mask_d[j] = mask_q[j];
          end
        end
        cfg_commit_d = 1'b1;
      end else if (wr_index_s == ADDR_CLR_ERR) begin
        frame_err_d  = 1'b0;
        cfg_commit_d = 1'b1;
      end else begin
        cfg_commit_d = 1'b0;
      end
    end else if (err_pulse_s) begin
      frame_err_d = 1'b1;
    end else begin
      frame_err_d = frame_err_q;
    end
  end

  // Register stage: inputs idle high, masks back to passthrough.
  always_ff @(posedge clk) begin
    if (reset) begin
      midi_sync_q  <= '1;
      midi_out_q   <= '1;
      cfg_commit_q <= 1'b0;
      frame_err_q  <= 1'b0;
      for (int j = 0; j < N_OUT; j++) begin
        mask_q[j] <= passthrough_mask(j);
      end
    end else begin
      midi_sync_q  <= midi_sync_d;
      midi_out_q   <= midi_out_d;
      cfg_commit_q <= cfg_commit_d;
      frame_err_q  <= frame_err_d;
      mask_q       <= mask_d;
    end
  end

endmodule

// File: tb/tb_midi_router_matrix.sv
// Self-checking bench for midi_router_matrix with a behavioural reference model.
module tb_midi_router_matrix;

  localparam int N_IN  = 8;
  localparam int N_OUT = 8;
  localparam int SYNC  = 2;
  localparam int H     = 6;  // SPI half period in clk cycles

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] midi_in = 8'hFF;
  logic [7:0] midi_out;
  logic       spi_clk = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_ss = 1'b1;
  logic       spi_miso;
  logic       cfg_commit;
  logic       frame_err;

  always #5 clk = ~clk;

  midi_router_matrix #(
    .N_IN        (N_IN),
    .N_OUT       (N_OUT),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .midi_in    (midi_in),
    .midi_out   (midi_out),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_ss     (spi_ss),
    .spi_miso   (spi_miso),
    .cfg_commit (cfg_commit),
    .frame_err  (frame_err)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;

  // Reference model state.
  logic [7:0] m_mask [8];
  logic       m_err = 1'b0;
  bit         checking = 1'b0;
  bit         midi_rand = 1'b0;
  int         cyc = 0;
  int         quiet_until = 0;
  int         commit_seen = 0;
  logic [7:0] d1_m = 8'hFF;
  logic [7:0] d2_m = 8'hFF;
  logic [7:0] exp_out = 8'hFF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // An output is high exactly when every input it listens to is high.
  function automatic logic [7:0] route(input logic [7:0] ins);
    logic [7:0] r;
    for (int j = 0; j < 8; j++) r[j] = ((ins & m_mask[j]) == m_mask[j]);
    return r;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 8; j++) m_mask[j] = 8'd1 << j;
    m_err = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Input-to-output delay line of the model: pin value reaches the output
  // three clocks after it is first sampled.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      d1_m <= 8'hFF; d2_m <= 8'hFF; exp_out <= 8'hFF;
    end else begin
      exp_out <= route(d2_m);
      d2_m    <= d1_m;
      d1_m    <= midi_in;
    end
  end

  // Per-cycle comparison against the model outside frame-end windows.
  always @(negedge clk) begin
    if (cfg_commit === 1'b1) commit_seen <= commit_seen + 1;
    if (checking && cyc >= quiet_until) begin
      chk("midi_out", 32'(midi_out), 32'(exp_out));
      chk("cfg_commit_idle", 32'(cfg_commit), 32'd0);
      chk("frame_err", 32'(frame_err), 32'(m_err));
      if (spi_ss) chk("miso_idle", 32'(spi_miso), 32'd0);
    end
  end

  // Background MIDI traffic, offset from the stimulus drive point.
  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (midi_rand) midi_in = 8'($urandom);
    end
  end

  // SPI master: sends nbits of word MSB first (bit 16 is a trailing 0),
  // optionally pulses reset before bit rst_bit, then updates the model.
  task automatic spi_frame(input logic [15:0] word, input int nbits, input int rst_bit,
                           output logic [7:0] rd);
    logic [6:0] idx;
    logic [7:0] exp_rd;
    logic       bv;
    int         c0;
    int         exp_commit;
    idx    = word[14:8];
    exp_rd = (idx < 7'd8) ? m_mask[idx[2:0]] : 8'h00;
    rd     = 8'h00;
    c0     = commit_seen;
    spi_ss = 1'b0;
    tick(H);
    for (int b = 0; b < nbits; b++) begin
      if (b == rst_bit) begin
        reset = 1'b1;
        model_reset();
        quiet_until = cyc + 20;
        tick(2);
        reset = 1'b0;
      end
      bv = (b < 16) ? word[15-b] : 1'b0;
      spi_mosi = bv;
      if (b == 16) begin
        m_err = 1'b1;
        quiet_until = cyc + 3 * H + 10;
      end
      tick(H);
      if (b >= 8 && b < 16) begin
        rd = {rd[6:0], spi_miso};
        if (rst_bit < 0) chk($sformatf("miso_bit%0d", b), 32'(spi_miso), 32'(exp_rd[15-b]));
      end
      spi_clk = 1'b1;
      tick(H);
      spi_clk = 1'b0;
    end
    tick(H);
    spi_ss = 1'b1;
    quiet_until = cyc + 10;
    exp_commit = 0;
    if (rst_bit >= 0) begin
      exp_commit = 0;
    end else if (nbits != 16) begin
      m_err = 1'b1;
    end else if (word[15]) begin
      if (idx < 7'd8) begin
        m_mask[idx[2:0]] = word[7:0];
        exp_commit = 1;
      end else if (idx == 7'h7F) begin
        m_err = 1'b0;
        exp_commit = 1;
      end
    end
    tick(10);
    chk($sformatf("commit_count_%04h", word), 32'(commit_seen - c0), 32'(exp_commit));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    logic [15:0] w;
    int r, nb;
    model_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_midi_out", 32'(midi_out), 32'h000000FF);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    chk("reset_cfg_commit", 32'(cfg_commit), 32'd0);
    chk("reset_miso", 32'(spi_miso), 32'd0);
    checking = 1'b1;

    // Latency of a single input edge through the passthrough default.
    tick(4);
    midi_in[3] = 1'b0;
    tick(2);
    @(negedge clk);
    chk("latency_before", 32'(midi_out), 32'h000000FF);
    tick(1);
    @(negedge clk);
    chk("latency_at", 32'(midi_out), 32'h000000F7);
    tick(1);
    midi_in = 8'hFF;
    tick(4);

    midi_rand = 1'b1;
    spi_frame(16'h8205, 16, -1, rd);
    midi_rand = 1'b0;
    midi_in = 8'hF6;
    tick(4);
    @(negedge clk);
    chk("route_after_8205", 32'(midi_out), 32'h000000F2);

    midi_rand = 1'b1;
    spi_frame(16'h0200, 16, -1, rd);
    chk("readback_0200", 32'(rd), 32'h00000005);

    spi_frame(16'h8303, 11, -1, rd);
    chk("short_frame_err", 32'(frame_err), 32'd1);
    spi_frame(16'hFF00, 16, -1, rd);
    chk("clear_err", 32'(frame_err), 32'd0);

    spi_frame(16'h8180, 17, -1, rd);
    chk("long_frame_err", 32'(frame_err), 32'd1);
    midi_rand = 1'b0;
    midi_in = 8'hFD;
    tick(4);
    @(negedge clk);
    chk("mask1_kept", 32'(midi_out), 32'h000000FD);
    midi_rand = 1'b1;
    spi_frame(16'hFF00, 16, -1, rd);

    spi_frame(16'h8433, 16, 12, rd);
    midi_rand = 1'b0;
    midi_in = 8'hFE;
    tick(4);
    @(negedge clk);
    chk("defaults_after_reset", 32'(midi_out), 32'h000000FE);
    spi_frame(16'h8501, 16, -1, rd);
    midi_in = 8'hFE;
    tick(4);
    @(negedge clk);
    chk("accept_after_reset", 32'(midi_out), 32'h000000DE);

    midi_rand = 1'b1;
    for (int n = 0; n < 30; n++) begin
      w = 16'($urandom);
      r = $urandom_range(0, 9);
      if (r < 8) w[14:8] = 7'($urandom_range(0, 7));
      else if (r == 8) w[14:8] = 7'h7F;
      else w[14:8] = 7'($urandom_range(8, 126));
      r = $urandom_range(0, 9);
      if (r == 0) nb = $urandom_range(4, 15);
      else if (r == 1) nb = 17;
      else nb = 16;
      spi_frame(w, nb, -1, rd);
    end
    tick(10);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
